// File: rtl/execute_if.sv
// Execute-stage bus bundle: decode->E handshake, E->M handshake, forwarding
// bus back to decode and the data-SRAM request port.
interface execute_if;
  localparam int DE_BUS_Wid     = 235;
  localparam int EM_BUS_Wid     = 193;
  localparam int ED_for_BUS_Wid = 38;

  logic                      DE_valid;
  logic [DE_BUS_Wid-1:0]     DE_BUS;
  logic                      E_allowin;
  logic                      EM_valid;
  logic [EM_BUS_Wid-1:0]     EM_BUS;
  logic                      M_allowin;
  logic [ED_for_BUS_Wid-1:0] ED_for_BUS;
  logic                      data_sram_en;
  logic [3:0]                data_sram_we;
  logic [31:0]               data_sram_addr;
  logic [31:0]               data_sram_wdata;

  modport master (
    input  DE_valid, DE_BUS, M_allowin,
    output E_allowin, EM_valid, EM_BUS, ED_for_BUS,
           data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
  );

  modport slave (
    output DE_valid, DE_BUS, M_allowin,
    input  E_allowin, EM_valid, EM_BUS, ED_for_BUS,
           data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
  );
endinterface

// File: rtl/execute.sv
// Execute stage: pipeline register, ALU, 32-cycle restoring divider,
// alignment-exception detection and data-SRAM request issue.
module execute (
  input  logic      clk,
  input  logic      rstn,
  input  logic      flush,
  execute_if.master bus
);

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  alu_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] rkd_value;
    logic        div_en;
    logic [1:0]  div_op;
    logic        gr_we;
    logic [4:0]  dest;
    logic [3:0]  res_from_mem;
    logic [2:0]  st_op;
    logic        ex;
    logic [5:0]  ecode;
    logic        esubcode;
    logic [13:0] csr_addr;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wdata;
  } de_bus_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rf_wdata;
    logic        gr_we;
    logic [4:0]  dest;
    logic [3:0]  res_from_mem;
    logic [31:0] vaddr;
    logic        ex;
    logic [5:0]  ecode;
    logic        esubcode;
    logic [13:0] csr_addr;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wdata;
  } em_bus_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

  logic       e_valid;
  de_bus_t    de_r;
  div_state_t div_state, div_next;
  logic [4:0] div_cnt;
  logic [31:0] div_rem, div_quo;

  logic e_ready_go, e_allowin;
  assign e_ready_go = !de_r.div_en || (div_state == DONE);
  assign e_allowin  = !e_valid || (e_ready_go && bus.M_allowin);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      e_valid <= 1'b0;
      de_r    <= '0;
    end else begin
      if (flush)          e_valid <= 1'b0;
      else if (e_allowin) e_valid <= bus.DE_valid;
      if (bus.DE_valid && e_allowin) de_r <= bus.DE_BUS;
    end
  end

  // Divider operates on magnitudes; signs are reapplied on the way out.
  logic        div_signed, src1_neg, src2_neg, div_take;
  logic [31:0] src1_mag, src2_mag, quo_fix, rem_fix, div_result;
  logic [32:0] rem_shift, rem_diff;

  assign div_signed = !de_r.div_op[0];
  assign src1_neg   = div_signed && de_r.src1[31];
  assign src2_neg   = div_signed && de_r.src2[31];
  assign src1_mag   = src1_neg ? -de_r.src1 : de_r.src1;
  assign src2_mag   = src2_neg ? -de_r.src2 : de_r.src2;
  assign rem_shift  = {div_rem, div_quo[31]};
  assign rem_diff   = rem_shift - {1'b0, src2_mag};
  assign div_take   = !rem_diff[32];

  // NOTE: next-state is assigned a default before any branch so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    div_next = div_state;
    case (div_state)
      IDLE:    if (e_valid && de_r.div_en && !flush) div_next = BUSY;
      BUSY:    if (div_cnt == 5'd31) div_next = DONE;
      DONE:    if (e_valid && bus.M_allowin) div_next = IDLE;
      default: div_next = IDLE;
    endcase
    if (flush) div_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      div_state <= IDLE;
      div_cnt   <= 5'd0;
      div_rem   <= '0;
      div_quo   <= '0;
    end else begin
      div_state <= div_next;
      if (div_state == IDLE && div_next == BUSY) begin
        div_cnt <= 5'd0;
        div_rem <= '0;
        div_quo <= src1_mag;
      end else if (div_state == BUSY) begin
        div_cnt <= div_cnt + 5'd1;
        div_rem <= div_take ? rem_diff[31:0] : rem_shift[31:0];
        div_quo <= {div_quo[30:0], div_take};
      end
    end
  end

  assign quo_fix = (src1_neg ^ src2_neg) ? -div_quo : div_quo;
  assign rem_fix = src1_neg ? -div_rem : div_rem;

  // Zero divisor bypasses the iteration result entirely.
  always_comb begin
    if (de_r.src2 == 32'd0) div_result = de_r.div_op[1] ? de_r.src1 : 32'hFFFF_FFFF;
    else                    div_result = de_r.div_op[1] ? rem_fix : quo_fix;
  end

  logic [31:0] alu_result, vaddr, rf_wdata;
  logic [4:0]  sh;
  assign sh    = de_r.src2[4:0];
  assign vaddr = de_r.src1 + de_r.src2;

  always_comb begin
    alu_result = '0;
    case (de_r.alu_op)
      4'd0:  alu_result = vaddr;
      4'd1:  alu_result = de_r.src1 - de_r.src2;
      4'd2:  alu_result = {31'd0, $signed(de_r.src1) < $signed(de_r.src2)};
      4'd3:  alu_result = {31'd0, de_r.src1 < de_r.src2};
      4'd4:  alu_result = de_r.src1 & de_r.src2;
      4'd5:  alu_result = de_r.src1 | de_r.src2;
      4'd6:  alu_result = ~(de_r.src1 | de_r.src2);
      4'd7:  alu_result = de_r.src1 ^ de_r.src2;
      4'd8:  alu_result = de_r.src1 << sh;
      4'd9:  alu_result = de_r.src1 >> sh;
      4'd10: alu_result = $signed(de_r.src1) >>> sh;
      4'd11: alu_result = de_r.src2;
      default: alu_result = '0;
    endcase
  end

  assign rf_wdata = de_r.div_en ? div_result : alu_result;

  logic       mem_access, misaligned, ex_final, esub_final;
  logic [5:0] ecode_final;
  assign mem_access = (|de_r.res_from_mem) || (|de_r.st_op);
  assign misaligned = mem_access &&
                      (((de_r.res_from_mem[1] || de_r.st_op[1]) && vaddr[0]) ||
                       ((de_r.res_from_mem[3] || de_r.st_op[2]) && (vaddr[1:0] != 2'b00)));
  // An upstream exception wins over a locally detected misalignment.
  assign ex_final    = de_r.ex || misaligned;
  assign ecode_final = (!de_r.ex && misaligned) ? 6'h09 : de_r.ecode;
  assign esub_final  = (!de_r.ex && misaligned) ? 1'b0  : de_r.esubcode;

  logic       sram_en;
  logic [3:0] sram_we;
  logic [31:0] sram_wdata;
  // Strobe only on the cycle the instruction actually moves to M.
  assign sram_en = e_valid && e_ready_go && bus.M_allowin && !flush && !ex_final && mem_access;

  always_comb begin
    sram_we = 4'h0;
    if (sram_en) begin
      if (de_r.st_op[2])      sram_we = 4'hF;
      else if (de_r.st_op[1]) sram_we = 4'b0011 << {vaddr[1], 1'b0};
      else if (de_r.st_op[0]) sram_we = 4'b0001 << vaddr[1:0];
    end
  end

  always_comb begin
    sram_wdata = de_r.rkd_value;
    if (de_r.st_op[0])      sram_wdata = {4{de_r.rkd_value[7:0]}};
    else if (de_r.st_op[1]) sram_wdata = {2{de_r.rkd_value[15:0]}};
  end

  em_bus_t em;
  always_comb begin
    em              = '0;
    em.pc           = de_r.pc;
    em.rf_wdata     = rf_wdata;
    em.gr_we        = de_r.gr_we;
    em.dest         = de_r.dest;
    em.res_from_mem = de_r.res_from_mem;
    em.vaddr        = vaddr;
    em.ex           = ex_final;
    em.ecode        = ecode_final;
    em.esubcode     = esub_final;
    em.csr_addr     = de_r.csr_addr;
    em.csr_we       = de_r.csr_we;
    em.csr_wmask    = de_r.csr_wmask;
    em.csr_wdata    = de_r.csr_wdata;
  end

  assign bus.E_allowin       = e_allowin;
  assign bus.EM_valid        = e_valid && e_ready_go;
  assign bus.EM_BUS          = em;
  assign bus.ED_for_BUS      = {e_valid && (|de_r.res_from_mem),
                                (e_valid && de_r.gr_we) ? de_r.dest : 5'd0,
                                rf_wdata};
  assign bus.data_sram_en    = sram_en;
  assign bus.data_sram_we    = sram_we;
  assign bus.data_sram_addr  = vaddr;
  assign bus.data_sram_wdata = sram_wdata;

endmodule

// File: tb/tb_execute.sv
// Scoreboard bench for the execute stage: a driver pushes model results on
// each accepted instruction, a negedge monitor checks timing and payload.
module tb_execute;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  alu_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] rkd_value;
    logic        div_en;
    logic [1:0]  div_op;
    logic        gr_we;
    logic [4:0]  dest;
    logic [3:0]  res_from_mem;
    logic [2:0]  st_op;
    logic        ex;
    logic [5:0]  ecode;
    logic        esubcode;
    logic [13:0] csr_addr;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wdata;
  } de_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rf_wdata;
    logic        gr_we;
    logic [4:0]  dest;
    logic [3:0]  res_from_mem;
    logic [31:0] vaddr;
    logic        ex;
    logic [5:0]  ecode;
    logic        esubcode;
    logic [13:0] csr_addr;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wdata;
  } em_t;

  typedef struct {
    de_t d;
    em_t em;
    int  lat;
    int  push_cyc;
  } sb_t;

  logic clk = 1'b0;
  logic rstn;
  logic flush;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   pulses = 0;
  bit   mon_on = 1'b0;
  bit   rand_mode = 1'b0;
  sb_t  sbq[$];

  execute_if bus();
  execute dut (.clk(clk), .rstn(rstn), .flush(flush), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on 64-bit integers.
  function automatic em_t model(input de_t d);
    em_t    e;
    longint sa, sb, ua, ub, na, nb, p, q, r, v;
    logic [31:0] alu, res;
    bit     mem, mis;
    sa = longint'($signed(d.src1));
    sb = longint'($signed(d.src2));
    ua = longint'({32'd0, d.src1});
    ub = longint'({32'd0, d.src2});
    p  = longint'(1) << d.src2[4:0];
    case (d.alu_op)
      4'd0:  v = ua + ub;
      4'd1:  v = ua - ub;
      4'd2:  v = (sa < sb) ? 1 : 0;
      4'd3:  v = (ua < ub) ? 1 : 0;
      4'd4:  v = longint'(d.src1 & d.src2);
      4'd5:  v = longint'(d.src1 | d.src2);
      4'd6:  v = longint'(~(d.src1 | d.src2));
      4'd7:  v = longint'(d.src1 ^ d.src2);
      4'd8:  v = ua * p;
      4'd9:  v = ua / p;
      4'd10: v = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
      4'd11: v = ub;
      default: v = 0;
    endcase
    alu = v[31:0];
    if (!d.div_op[0]) begin na = sa; nb = sb; end
    else              begin na = ua; nb = ub; end
    if (nb == 0) begin q = -1; r = na; end
    else         begin q = na / nb; r = na % nb; end
    res = d.div_en ? (d.div_op[1] ? r[31:0] : q[31:0]) : alu;
    e = '0;
    e.pc = d.pc; e.rf_wdata = res; e.gr_we = d.gr_we; e.dest = d.dest;
    e.res_from_mem = d.res_from_mem;
    e.vaddr = d.src1 + d.src2;
    mem = (d.res_from_mem != 0) || (d.st_op != 0);
    mis = mem && (((d.res_from_mem[1] || d.st_op[1]) && (e.vaddr % 2 != 0)) ||
                  ((d.res_from_mem[3] || d.st_op[2]) && (e.vaddr % 4 != 0)));
    e.ex = d.ex; e.ecode = d.ecode; e.esubcode = d.esubcode;
    if (!d.ex && mis) begin e.ex = 1'b1; e.ecode = 6'h09; e.esubcode = 1'b0; end
    e.csr_addr = d.csr_addr; e.csr_we = d.csr_we;
    e.csr_wmask = d.csr_wmask; e.csr_wdata = d.csr_wdata;
    return e;
  endfunction

  // Monitor: E contents are exactly the scoreboard head (0 or 1 entries).
  always @(negedge clk) begin
    sb_t e;
    bit exp_emv, exp_alw, exp_en;
    logic [3:0] exp_we;
    logic [31:0] exp_wd;
    int a;
    if (mon_on) begin
      exp_emv = (sbq.size() != 0) && (cyc - sbq[0].push_cyc >= sbq[0].lat);
      check("em_valid", 256'(bus.EM_valid), 256'(exp_emv));
      exp_alw = (sbq.size() == 0) || (exp_emv && bus.M_allowin);
      check("e_allowin", 256'(bus.E_allowin), 256'(exp_alw));
      if (sbq.size() == 0) check("fwd_idle", 256'(bus.ED_for_BUS[37:32]), 256'(0));
      if (exp_emv && bus.M_allowin && !flush) begin
        e = sbq.pop_front();
        check("em_bus", 256'(bus.EM_BUS), 256'(e.em));
        check("fwd_bus", 256'(bus.ED_for_BUS),
              256'({e.d.res_from_mem != 0, e.d.gr_we ? e.d.dest : 5'd0, e.em.rf_wdata}));
        exp_en = ((e.d.res_from_mem != 0) || (e.d.st_op != 0)) && !e.em.ex;
        a = int'(e.em.vaddr % 4);
        exp_we = 4'h0;
        exp_wd = e.d.rkd_value;
        if (e.d.st_op[2]) exp_we = 4'hF;
        else if (e.d.st_op[1]) begin
          exp_we = (a >= 2) ? 4'b1100 : 4'b0011;
          exp_wd = {e.d.rkd_value[15:0], e.d.rkd_value[15:0]};
        end else if (e.d.st_op[0]) begin
          exp_we = 4'(1 << a);
          exp_wd = {4{e.d.rkd_value[7:0]}};
        end
        if (!exp_en) exp_we = 4'h0;
        check("sram_en", 256'(bus.data_sram_en), 256'(exp_en));
        check("sram_we", 256'(bus.data_sram_we), 256'(exp_we));
        if (exp_en) check("sram_addr", 256'(bus.data_sram_addr), 256'(e.em.vaddr));
        if (exp_en && e.d.st_op != 0) check("sram_wdata", 256'(bus.data_sram_wdata), 256'(exp_wd));
      end else begin
        check("sram_idle", 256'({bus.data_sram_en, bus.data_sram_we}), 256'(0));
      end
      if (flush) sbq.delete();
      if (bus.data_sram_en) pulses++;
    end
  end

  task automatic cycle(input bit dv, input de_t ins, input bit fl, input bit ma, output bit acc);
    sb_t e;
    @(posedge clk); #1;
    bus.DE_valid = dv; bus.DE_BUS = ins; flush = fl; bus.M_allowin = ma;
    @(negedge clk);
    acc = bus.E_allowin && dv && !fl;
    #1;
    if (acc) begin
      e.d = ins; e.em = model(ins);
      e.lat = ins.div_en ? 34 : 1;
      e.push_cyc = cyc;
      sbq.push_back(e);
    end
  endtask

  task automatic issue(input de_t ins);
    bit done = 1'b0;
    for (int k = 0; k < 300 && !done; k++)
      cycle(1'b1, ins, rand_mode && ($urandom_range(0, 49) == 0),
            rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1, done);
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL issue_timeout @%0t: instruction never accepted", $time);
    end
  endtask

  task automatic idle(input int n, input bit ma);
    bit acc;
    for (int k = 0; k < n; k++) cycle(1'b0, '0, 1'b0, ma, acc);
  endtask

  task automatic drain();
    bit acc;
    for (int k = 0; k < 200 && sbq.size() != 0; k++) cycle(1'b0, '0, 1'b0, 1'b1, acc);
    if (sbq.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout @%0t: %0d entries left", $time, sbq.size());
    end
  endtask

  function automatic de_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    de_t d = '0;
    d.pc = $urandom & 32'hFFFF_FFFC;
    d.alu_op = op; d.src1 = a; d.src2 = b;
    d.gr_we = 1'b1; d.dest = 5'($urandom_range(1, 31));
    return d;
  endfunction

  function automatic de_t mk_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    de_t d = mk(4'd0, a, b);
    d.div_en = 1'b1; d.div_op = op;
    return d;
  endfunction

  function automatic de_t mk_mem(input logic [3:0] ld, input logic [2:0] st,
                                 input logic [31:0] addr, input logic [31:0] rkd);
    de_t d = mk(4'd0, addr & 32'hFFFF_FFF0, addr & 32'h0000_000F);
    d.res_from_mem = ld; d.st_op = st; d.rkd_value = rkd;
    d.gr_we = (ld != 0);
    return d;
  endfunction

  function automatic de_t rand_ins();
    de_t d;
    int  k = $urandom_range(0, 9);
    logic [31:0] a = $urandom;
    if (k < 4) begin
      d = mk(4'($urandom_range(0, 15)), a, ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)));
    end else if (k < 6) begin
      case ($urandom_range(0, 5))
        0: d = mk_div(2'($urandom), a, 32'd0);
        1: d = mk_div(2'b00 | 2'($urandom_range(0, 1) << 1), 32'h8000_0000, 32'hFFFF_FFFF);
        2: d = mk_div(2'($urandom), a, 32'($urandom_range(1, 100)));
        default: d = mk_div(2'($urandom), a, $urandom);
      endcase
    end else if (k < 8) begin
      case ($urandom_range(0, 2))
        0: d = mk_mem(4'b1000, 3'b000, 32'h1000_0000 | ($urandom & 32'hFFFF), 32'd0);
        1: d = mk_mem(4'b0010 | 4'($urandom_range(0, 1) << 2), 3'b000, 32'h1000_0000 | ($urandom & 32'hFFFF), 32'd0);
        default: d = mk_mem(4'b0001 | 4'($urandom_range(0, 1) << 2), 3'b000, 32'h1000_0000 | ($urandom & 32'hFFFF), 32'd0);
      endcase
    end else begin
      d = mk_mem(4'b0000, 3'(1 << $urandom_range(0, 2)), 32'h2000_0000 | ($urandom & 32'hFFFF), $urandom);
    end
    d.csr_addr = 14'($urandom); d.csr_we = 1'($urandom);
    d.csr_wmask = $urandom; d.csr_wdata = $urandom;
    if ($urandom_range(0, 9) == 0) begin
      d.ex = 1'b1; d.ecode = 6'($urandom); d.esubcode = 1'($urandom);
    end
    return d;
  endfunction

  initial begin
    de_t d;
    bit  acc;
    rstn = 1'b0; flush = 1'b0;
    bus.DE_valid = 1'b0; bus.DE_BUS = '0; bus.M_allowin = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_em_valid", 256'(bus.EM_valid), 256'(0));
    check("rst_e_allowin", 256'(bus.E_allowin), 256'(1));
    check("rst_sram", 256'({bus.data_sram_en, bus.data_sram_we}), 256'(0));
    check("rst_fwd_dest", 256'(bus.ED_for_BUS[36:32]), 256'(0));
    @(posedge clk); #1;
    rstn = 1'b1;
    mon_on = 1'b1;

    // ALU corner values
    issue(mk(4'd0, 32'h7FFF_FFFF, 32'd1));
    issue(mk(4'd10, 32'h8000_0000, 32'd4));
    issue(mk(4'd3, 32'd1, 32'hFFFF_FFFF));
    issue(mk(4'd2, 32'hFFFF_FFFF, 32'd1));
    issue(mk(4'd13, 32'h1234_5678, 32'd9));
    // back-to-back divides: div, mod, divide-by-zero, overflow
    issue(mk_div(2'b00, 32'hFFFF_FFF9, 32'd2));
    issue(mk_div(2'b10, 32'hFFFF_FFF9, 32'd2));
    issue(mk_div(2'b00, 32'h0000_0064, 32'd0));
    issue(mk_div(2'b10, 32'hFFFF_FF9C, 32'd0));
    issue(mk_div(2'b00, 32'h8000_0000, 32'hFFFF_FFFF));
    issue(mk_div(2'b11, 32'hFFFF_FFF9, 32'd2));
    drain();
    // stores and alignment
    issue(mk_mem(4'b0000, 3'b001, 32'h0000_1003, 32'h1234_5678));
    issue(mk_mem(4'b0000, 3'b010, 32'h0000_1002, 32'h1234_5678));
    issue(mk_mem(4'b0000, 3'b100, 32'h0000_1004, 32'hDEAD_BEEF));
    issue(mk_mem(4'b1000, 3'b000, 32'h0000_1001, 32'd0));
    d = mk_mem(4'b1000, 3'b000, 32'h0000_1001, 32'd0);
    d.ex = 1'b1; d.ecode = 6'h0B;
    issue(d);
    issue(mk_mem(4'b0000, 3'b010, 32'h0000_1001, 32'hA5A5_A5A5));
    drain();
    // store held by M_allowin=0 for 3 cycles: exactly one request
    issue(mk_mem(4'b0000, 3'b100, 32'h0000_2000, 32'hCAFE_F00D));
    pulses = 0;
    idle(3, 1'b0);
    idle(2, 1'b1);
    check("stall_pulses", 256'(pulses), 256'(1));
    // flush during BUSY, then a fresh divide must take full latency
    issue(mk_div(2'b00, 32'd100, 32'd7));
    idle(5, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b1, acc);
    idle(2, 1'b1);
    issue(mk_div(2'b01, 32'hFFFF_FFFF, 32'd3));
    drain();
    // flush alongside DE_valid suppresses the entry
    cycle(1'b1, mk_mem(4'b0000, 3'b100, 32'h0000_3000, 32'h1), 1'b1, 1'b1, acc);
    idle(2, 1'b1);

    // randomized traffic with M backpressure and occasional flush
    rand_mode = 1'b1;
    for (int n = 0; n < 200; n++) begin
      issue(rand_ins());
      if ($urandom_range(0, 3) == 0) idle(1, $urandom_range(0, 3) != 0);
    end
    rand_mode = 1'b0;
    drain();
    idle(2, 1'b1);
    mon_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
